// File: rtl/eth_pkg.sv
// -----------------------------------------------------------------------------
// eth_pkg
// Shared Ethernet receive constants, the framer state type and the default
// frame-length limits used by gmii_rx_framer and crc32_d8.
// No ports (package).
// -----------------------------------------------------------------------------
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    // Good-frame residue expressed MSB-first; the LSB-first CRC register holds
    // the bit-reversed form of this value after a correct FCS.
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    localparam int MIN_FRAME_DEF = 64;
    localparam int MAX_FRAME_DEF = 1518;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } framer_state_t;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/gmii_rx_framer_if.sv
// -----------------------------------------------------------------------------
// gmii_rx_framer_if
// Bundles the GMII receive inputs and the framed byte-stream / status outputs
// of gmii_rx_framer.
//   rx_dv, rx_er, rxd           : GMII receive side (into the framer)
//   newpkt, dataValid, data     : framed byte stream (out of the framer)
//   pkt_end, pkt_err            : end-of-frame strobe and its error qualifier
//   frames_ok, frames_err       : wrapping good/bad frame counters
// modport master : the framer (drives the stream and counters)
// modport slave  : the environment (drives GMII, consumes the stream)
// -----------------------------------------------------------------------------
interface gmii_rx_framer_if;

    logic        rx_dv;
    logic        rx_er;
    logic [7:0]  rxd;
    logic        newpkt;
    logic        dataValid;
    logic [7:0]  data;
    logic        pkt_end;
    logic        pkt_err;
    logic [15:0] frames_ok;
    logic [15:0] frames_err;

    modport master (
        input  rx_dv, rx_er, rxd,
        output newpkt, dataValid, data, pkt_end, pkt_err, frames_ok, frames_err
    );

    modport slave (
        output rx_dv, rx_er, rxd,
        input  newpkt, dataValid, data, pkt_end, pkt_err, frames_ok, frames_err
    );

endinterface

// File: rtl/crc32_d8.sv
// -----------------------------------------------------------------------------
// crc32_d8
// Byte-wide Ethernet CRC-32 step (LSB-first, reflected polynomial, register
// preset to all ones, no final inversion).
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : preset the register to 32'hFFFFFFFF (wins over enable)
//   enable     : fold din into the register
//   din        : data byte
//   crc        : current register value
// -----------------------------------------------------------------------------
module crc32_d8
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  din,
    output logic [31:0] crc
);

    localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] step;

    always_comb begin
        step = crc_q ^ {24'd0, din};
        for (int i = 0; i < 8; i++) begin
            step = step[0] ? ((step >> 1) ^ POLY_REFL) : (step >> 1);
        end
        crc_d = crc_q;
        if (clear) begin
            crc_d = '1;
        end else if (enable) begin
            crc_d = step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '1;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/gmii_rx_framer.sv
// -----------------------------------------------------------------------------
// gmii_rx_framer
// Turns a raw GMII receive stream into the newpkt/dataValid/data byte stream:
// strips preamble and SFD, withholds the 4-byte FCS through a 4-deep delay
// pipe, flags runt / oversize / rx_er frames and counts good and bad frames.
//   CLOCK    : system clock, one GMII byte per cycle
//   RESET_N  : asynchronous active-low reset
//   bus      : gmii_rx_framer_if.master (GMII in, stream + status out)
// Parameters: MAX_FRAME / MIN_FRAME, frame length limits DA..FCS inclusive.
// Optional feature macro GMII_RX_FCS_CHECK_EN: when defined, a CRC-32 checks
// the FCS and a bad residue marks the frame as errored.
// -----------------------------------------------------------------------------
module gmii_rx_framer
    import eth_pkg::*;
#(
    parameter int MAX_FRAME = MAX_FRAME_DEF,
    parameter int MIN_FRAME = MIN_FRAME_DEF
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    gmii_rx_framer_if.master bus
);

    framer_state_t   state_q,      state_d;
    logic [3:0][7:0] pipe_q,       pipe_d;
    logic [2:0]      fill_q,       fill_d;
    logic [10:0]     length_q,     length_d;
    logic            err_q,        err_d;
    logic            framed_q,     framed_d;
    logic            newpkt_q,     newpkt_d;
    logic            dv_q,         dv_d;
    logic [7:0]      data_q,       data_d;
    logic            pkt_end_q,    pkt_end_d;
    logic            pkt_err_q,    pkt_err_d;
    logic [15:0]     frames_ok_q,  frames_ok_d;
    logic [15:0]     frames_err_q, frames_err_d;

    logic start_sfd;
    logic over_max;
    logic byte_acc;
    logic runt;
    logic crc_bad;
    logic frame_bad;

    always_comb begin
        start_sfd = bus.rx_dv && (bus.rxd == ETH_SFD) &&
                    ((state_q == ST_IDLE) || (state_q == ST_PREAMBLE));
        // The incoming byte would push the frame past MAX_FRAME.
        over_max  = ({1'b0, length_q} + 12'd1) > 12'(MAX_FRAME);
        byte_acc  = (state_q == ST_DATA) && bus.rx_dv && !over_max;
        runt      = 32'(length_q) < MIN_FRAME;
        frame_bad = err_q || runt || crc_bad;
    end

`ifdef GMII_RX_FCS_CHECK_EN
    logic [31:0] crc;

    crc32_d8 u_crc (
        .clk    (CLOCK),
        .rst_n  (RESET_N),
        .clear  (start_sfd),
        .enable (byte_acc),
        .din    (bus.rxd),
        .crc    (crc)
    );

    assign crc_bad = (reflect32(crc) != CRC32_RESIDUE);
`else
    assign crc_bad = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pipe_d       = pipe_q;
        fill_d       = fill_q;
        length_d     = length_q;
        err_d        = err_q;
        framed_d     = framed_q;
        newpkt_d     = 1'b0;
        dv_d         = 1'b0;
        data_d       = data_q;
        pkt_end_d    = 1'b0;
        pkt_err_d    = 1'b0;
        frames_ok_d  = frames_ok_q;
        frames_err_d = frames_err_q;

        case (state_q)
            ST_IDLE, ST_PREAMBLE: begin
                if (start_sfd) begin
                    state_d  = ST_DATA;
                    newpkt_d = 1'b1;
                    fill_d   = 3'd0;
                    length_d = 11'd0;
                    err_d    = 1'b0;
                    framed_d = 1'b1;
                end else if (bus.rx_dv && (bus.rxd == ETH_PREAMBLE)) begin
                    state_d = ST_PREAMBLE;
                end else if (bus.rx_dv) begin
                    state_d  = ST_DROP;
                    framed_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_DATA: begin
                if (byte_acc) begin
                    length_d = (&length_q) ? length_q : (length_q + 11'd1);
                    pipe_d   = {pipe_q[2:0], bus.rxd};
                    if (bus.rx_er) begin
                        err_d = 1'b1;
                    end
                    // Only bytes that have been followed by four more leave
                    // the pipe; whatever is left at rx_dv fall is the FCS.
                    if (fill_q == 3'd4) begin
                        dv_d   = 1'b1;
                        data_d = pipe_q[3];
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                end else if (bus.rx_dv) begin
                    err_d   = 1'b1;
                    state_d = ST_DROP;
                end else begin
                    state_d   = ST_IDLE;
                    framed_d  = 1'b0;
                    pkt_end_d = 1'b1;
                    pkt_err_d = frame_bad;
                    if (frame_bad) begin
                        frames_err_d = frames_err_q + 16'd1;
                    end else begin
                        frames_ok_d = frames_ok_q + 16'd1;
                    end
                end
            end

            ST_DROP: begin
                if (!bus.rx_dv) begin
                    state_d  = ST_IDLE;
                    framed_d = 1'b0;
                    // Only a frame that already announced newpkt gets closed.
                    if (framed_q) begin
                        pkt_end_d    = 1'b1;
                        pkt_err_d    = 1'b1;
                        frames_err_d = frames_err_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            pipe_q       <= '0;
            fill_q       <= '0;
            length_q     <= '0;
            err_q        <= 1'b0;
            framed_q     <= 1'b0;
            newpkt_q     <= 1'b0;
            dv_q         <= 1'b0;
            data_q       <= '0;
            pkt_end_q    <= 1'b0;
            pkt_err_q    <= 1'b0;
            frames_ok_q  <= '0;
            frames_err_q <= '0;
        end else begin
            state_q      <= state_d;
            pipe_q       <= pipe_d;
            fill_q       <= fill_d;
            length_q     <= length_d;
            err_q        <= err_d;
            framed_q     <= framed_d;
            newpkt_q     <= newpkt_d;
            dv_q         <= dv_d;
            data_q       <= data_d;
            pkt_end_q    <= pkt_end_d;
            pkt_err_q    <= pkt_err_d;
            frames_ok_q  <= frames_ok_d;
            frames_err_q <= frames_err_d;
        end
    end

    assign bus.newpkt     = newpkt_q;
    assign bus.dataValid  = dv_q;
    assign bus.data       = data_q;
    assign bus.pkt_end    = pkt_end_q;
    assign bus.pkt_err    = pkt_err_q;
    assign bus.frames_ok  = frames_ok_q;
    assign bus.frames_err = frames_err_q;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// -----------------------------------------------------------------------------
// tb_gmii_rx_framer
// Self-checking bench for gmii_rx_framer. Frames are built as byte bursts;
// a frame-level reference model derives the expected byte stream, strobes,
// timing and counters from each burst. Honours GMII_RX_FCS_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_gmii_rx_framer;

    localparam int MAXF = 1518;
    localparam int MINF = 64;
`ifdef GMII_RX_FCS_CHECK_EN
    localparam bit FCS_CHK = 1'b1;
`else
    localparam bit FCS_CHK = 1'b0;
`endif

    logic CLOCK   = 1'b0;
    logic RESET_N = 1'b0;

    gmii_rx_framer_if bus ();

    gmii_rx_framer #(
        .MAX_FRAME (MAXF),
        .MIN_FRAME (MINF)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLOCK = ~CLOCK;

    int n_cmp = 0;
    int n_bad = 0;
    int tick  = 0;

    logic [7:0] burst_d[$];
    logic       burst_e[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int   exp_np, got_np, exp_end, got_end;
    int   exp_ok, exp_errc;
    logic exp_err, got_err;
    int   exp_np_tick, got_np_tick, exp_dv_tick, got_dv_tick;
    int   exp_end_tick, got_end_tick, overlap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // One GMII cycle: drive after the edge, observe outputs on the falling edge.
    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(posedge CLOCK);
        #1;
        bus.rx_dv = dv;
        bus.rx_er = er;
        bus.rxd   = d;
        tick++;
        @(negedge CLOCK);
        if (bus.newpkt) begin
            got_np++;
            got_np_tick = tick;
            got_dv_tick = -1;
        end
        if (bus.dataValid) begin
            got_q.push_back(bus.data);
            if (got_dv_tick < 0) got_dv_tick = tick;
        end
        if (bus.newpkt && bus.dataValid) overlap++;
        if (bus.pkt_end) begin
            got_end++;
            got_end_tick = tick;
            got_err      = bus.pkt_err;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear_group();
        exp_q.delete();
        got_q.delete();
        exp_np = 0; got_np = 0; exp_end = 0; got_end = 0;
        exp_err = 1'b0; got_err = 1'b0;
        exp_np_tick = -1; got_np_tick = -1; exp_dv_tick = -1; got_dv_tick = -1;
        exp_end_tick = -1; got_end_tick = -1; overlap = 0;
    endtask

    // npre x 55, D5, then flen bytes (payload + FCS when flen >= 4).
    task automatic build(input int npre, input int flen, input bit seq, input int er_idx, input bit flip);
        logic [31:0] c;
        logic [7:0]  b;
        burst_d.delete();
        burst_e.delete();
        for (int i = 0; i < npre; i++) begin
            burst_d.push_back(8'h55);
            burst_e.push_back(1'b0);
        end
        burst_d.push_back(8'hD5);
        burst_e.push_back(1'b0);
        if (flen >= 4) begin
            c = 32'hFFFF_FFFF;
            for (int i = 0; i < flen - 4; i++) begin
                b = seq ? 8'(i) : 8'($urandom);
                burst_d.push_back(b);
                burst_e.push_back(i == er_idx);
                c = crc_upd(c, b);
            end
            c = ~c;
            if (flip) c[5] = ~c[5];
            for (int k = 0; k < 4; k++) begin
                burst_d.push_back(c[8*k +: 8]);
                burst_e.push_back(1'b0);
            end
        end else begin
            for (int i = 0; i < flen; i++) begin
                burst_d.push_back(8'($urandom));
                burst_e.push_back(1'b0);
            end
        end
    endtask

    // Reference model for one burst, then drive it.
    task automatic run_burst();
        int          n;
        int          i;
        int          len;
        int          shown;
        bit          framed;
        bit          bad;
        logic [31:0] c;
        logic [31:0] fcs;
        n = burst_d.size();
        i = 0;
        len = 0;
        shown = 0;
        while (i < n && burst_d[i] == 8'h55) i++;
        framed = (i < n) && (burst_d[i] == 8'hD5);
        if (framed) begin
            len = n - i - 1;
            exp_np++;
            exp_end++;
            bad = (len < MINF) || (len > MAXF);
            for (int k = 0; k < len; k++) if (burst_e[i + 1 + k]) bad = 1'b1;
            if (FCS_CHK) begin
                if (len < 4) begin
                    bad = 1'b1;
                end else begin
                    c = 32'hFFFF_FFFF;
                    for (int k = 0; k < len - 4; k++) c = crc_upd(c, burst_d[i + 1 + k]);
                    fcs = {burst_d[n-1], burst_d[n-2], burst_d[n-3], burst_d[n-4]};
                    if (fcs != ~c) bad = 1'b1;
                end
            end
            shown = ((len > MAXF) ? MAXF : len) - 4;
            for (int k = 0; k < shown; k++) exp_q.push_back(burst_d[i + 1 + k]);
            exp_err = bad;
            if (bad) exp_errc++;
            else     exp_ok++;
        end
        for (int j = 0; j < n; j++) begin
            drive(1'b1, burst_e[j], burst_d[j]);
            if (framed && j == i) begin
                exp_np_tick = tick + 1;
                exp_dv_tick = (shown > 0) ? tick + 6 : -1;
            end
        end
        if (framed) exp_end_tick = tick + 2;
    endtask

    task automatic check_group(input string tag);
        int diff;
        int m;
        diff = 0;
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < m; k++) if (got_q[k] !== exp_q[k]) diff++;
        check({tag, ".newpkt_cnt"},  got_np,        exp_np);
        check({tag, ".pkt_end_cnt"}, got_end,       exp_end);
        check({tag, ".nbytes"},      got_q.size(),  exp_q.size());
        check({tag, ".bytes_diff"},  diff,          0);
        check({tag, ".overlap"},     overlap,       0);
        check({tag, ".frames_ok"},   bus.frames_ok, exp_ok[15:0]);
        check({tag, ".frames_err"},  bus.frames_err, exp_errc[15:0]);
        if (exp_end > 0) check({tag, ".pkt_err"}, got_err, exp_err);
        if (exp_np > 0) begin
            check({tag, ".newpkt_t"},  got_np_tick,  exp_np_tick);
            check({tag, ".first_dv_t"}, got_dv_tick, exp_dv_tick);
            check({tag, ".pkt_end_t"}, got_end_tick, exp_end_tick);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int npre;
        int flen;
        int er_idx;
        bus.rx_dv = 1'b0;
        bus.rx_er = 1'b0;
        bus.rxd   = 8'h00;
        RESET_N   = 1'b0;
        repeat (3) @(negedge CLOCK);
        check("rst.newpkt",     bus.newpkt,     0);
        check("rst.dataValid",  bus.dataValid,  0);
        check("rst.data",       bus.data,       0);
        check("rst.pkt_end",    bus.pkt_end,    0);
        check("rst.pkt_err",    bus.pkt_err,    0);
        check("rst.frames_ok",  bus.frames_ok,  0);
        check("rst.frames_err", bus.frames_err, 0);
        RESET_N  = 1'b1;
        exp_ok   = 0;
        exp_errc = 0;
        clear_group();
        idle(2);

        // Good frame: 7x55, D5, payload 00..3B, FCS.
        clear_group(); build(7, 64, 1'b1, -1, 1'b0); run_burst(); idle(4); check_group("good");

        // Runt: 55, D5 + 40 bytes.
        clear_group(); build(1, 40, 1'b0, -1, 1'b0); run_burst(); idle(4); check_group("runt");

        // rx_er on byte 20 of a 100-byte frame.
        clear_group(); build(7, 100, 1'b0, 20, 1'b0); run_burst(); idle(4); check_group("rx_er");

        // Oversize 1600-byte frame.
        clear_group(); build(7, 1600, 1'b0, -1, 1'b0); run_burst(); idle(4); check_group("oversize");

        // Bad preamble 55,55,AA,... then a good frame after one idle cycle.
        clear_group();
        burst_d.delete(); burst_e.delete();
        burst_d.push_back(8'h55); burst_d.push_back(8'h55); burst_d.push_back(8'hAA);
        for (int k = 0; k < 3; k++) burst_e.push_back(1'b0);
        for (int k = 0; k < 20; k++) begin
            burst_d.push_back(8'($urandom));
            burst_e.push_back(1'b0);
        end
        run_burst(); idle(1);
        build(7, 80, 1'b0, -1, 1'b0); run_burst(); idle(4);
        check_group("badpre");

        // Back-to-back good frames with a single idle cycle.
        clear_group();
        build(3, 70, 1'b0, -1, 1'b0); run_burst(); idle(1);
        build(1, 66, 1'b0, -1, 1'b0); run_burst(); idle(4);
        check_group("b2b");

        // Correct FCS, then the same length with one FCS bit flipped.
        clear_group(); build(7, 90, 1'b1, -1, 1'b0); run_burst(); idle(4); check_group("fcs_ok");
        clear_group(); build(7, 90, 1'b1, -1, 1'b1); run_burst(); idle(4); check_group("fcs_flip");

        // Randomised frames.
        for (int r = 0; r < 10; r++) begin
            npre   = $urandom_range(1, 7);
            flen   = $urandom_range(0, 200);
            er_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 199)) : -1;
            clear_group();
            build(npre, flen, 1'b0, er_idx, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) burst_d[0] = 8'h12;
            run_burst();
            idle(2);
            check_group("rand");
        end

        // Reset in the middle of a frame.
        clear_group();
        build(7, 100, 1'b0, -1, 1'b0);
        for (int j = 0; j < 40; j++) drive(1'b1, 1'b0, burst_d[j]);
        @(posedge CLOCK);
        #1;
        RESET_N   = 1'b0;
        bus.rx_dv = 1'b0;
        #1;
        check("midrst.dataValid",  bus.dataValid,  0);
        check("midrst.newpkt",     bus.newpkt,     0);
        check("midrst.frames_ok",  bus.frames_ok,  0);
        check("midrst.frames_err", bus.frames_err, 0);
        @(negedge CLOCK);
        RESET_N  = 1'b1;
        exp_ok   = 0;
        exp_errc = 0;
        clear_group();
        idle(2);
        build(7, 64, 1'b1, -1, 1'b0); run_burst(); idle(4);
        check_group("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
